// File: rtl/md_unit_pkg.sv
// Shared encodings and default latencies for the E-stage multiply/divide unit.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF  = 10;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit result for mult/multu/madd/div/divu; returns {hi,lo} unchanged on divide by zero.
module md_arith
  import md_unit_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo,
  output logic [63:0] res
);

  logic signed [63:0] sa_64, sb_64, sprod;
  logic        [63:0] uprod;
  logic signed [31:0] sa, sb, sdiv, sq, sr;
  logic        [31:0] udiv, uq, ur;
  logic               div_zero, div_ovf;

  assign sa_64 = {{32{a[31]}}, a};
  assign sb_64 = {{32{b[31]}}, b};
  assign sprod = sa_64 * sb_64;
  assign uprod = {32'b0, a} * {32'b0, b};

  assign sa       = a;
  assign sb       = b;
  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Divisor is forced to 1 in the cases handled separately, so the dividers never see 0 or INT_MIN/-1.
  assign sdiv = (div_zero || div_ovf) ? 32'sd1 : sb;
  assign udiv = div_zero ? 32'd1 : b;
  assign sq   = sa / sdiv;
  assign sr   = sa % sdiv;
  assign uq   = a / udiv;
  assign ur   = a % udiv;

  always_comb begin
    res = hilo;
    case (op)
      MD_MULT:  res = sprod;
      MD_MULTU: res = uprod;
      MD_MADD:  res = hilo + sprod;
      MD_DIV: begin
        if (div_zero)     res = hilo;
        else if (div_ovf) res = {32'd0, 32'h8000_0000};
        else              res = {sr, sq};
      end
      MD_DIVU:  res = div_zero ? hilo : {ur, uq};
      default:  res = hilo;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy covers the whole operation latency.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT_DEF,
  parameter int DIV_LAT  = MD_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        op_err
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  md_state_e          state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               err_n, res_ld, wb, mt_hi, mt_lo;
  logic [63:0]        arith_res;
  logic [31:0]        res_hi, res_lo;
  md_op_e             op;

  assign op   = md_op_e'(md_op);
  assign busy = (state == MD_RUN);

  md_arith u_arith (
    .op   (op),
    .a    (src_a),
    .b    (src_b),
    .hilo ({hi, lo}),
    .res  (arith_res)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = 1'b0;
    res_ld  = 1'b0;
    wb      = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    case (state)
      MD_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU, MD_MADD, MD_DIV, MD_DIVU: begin
              state_n = MD_RUN;
              res_ld  = 1'b1;
              cnt_n   = md_is_div(op) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
            end
            MD_MTHI: mt_hi = 1'b1;
            MD_MTLO: mt_lo = 1'b1;
            default: err_n = 1'b1;
          endcase
        end
      end
      MD_RUN: begin
        // Any request while an operation is in flight is dropped, including mthi/mtlo.
        err_n = start;
        if (cnt == '0) begin
          wb      = 1'b1;
          state_n = MD_IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      op_err <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      op_err <= err_n;
      if (wb) begin
        hi <= res_hi;
        lo <= res_lo;
      end else begin
        if (mt_hi) hi <= src_a;
        if (mt_lo) lo <= src_a;
      end
    end
  end

  // Result is computed at the start edge from the operands and HI/LO of that edge, then held until writeback.
  always_ff @(posedge clk) begin
    if (res_ld) {res_hi, res_lo} <= arith_res;
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO and latency, a negedge monitor checks on busy fall.
module tb_md_unit;
  import md_unit_pkg::*;

  typedef struct {
    string       name;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy, op_err;
  logic [31:0] hi, lo;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   err_seen = 0;
  int   run_cnt = 0;
  logic prev_busy = 1'b0;

  md_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .md_op  (md_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .op_err (op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_busy = 1'b0;
      run_cnt   = 0;
    end else begin
      if (op_err) err_seen++;
      if (busy) begin
        run_cnt++;
      end else if (prev_busy) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got=busy_fall want=none");
        end else begin
          e = q.pop_front();
          chk({e.name, "_lat"}, 32'(run_cnt), 32'(e.lat));
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
        end
        run_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle_timeout: got=busy want=idle");
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] ehi,
                        input logic [31:0] elo);
    exp_t e;
    e.name = name;
    e.lat  = lat;
    e.hi   = ehi;
    e.lo   = elo;
    q.push_back(e);
    issue(op, a, b);
    chk({name, "_busy_on"}, 32'(busy), 32'd1);
    wait_idle(40);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_err", 32'(op_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mult",   MD_MULT,  32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div",    MD_DIV,   32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0",  MD_DIVU,  32'd7,         32'd0,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divovf", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,        32'h8000_0000);
    run_op("divu",   MD_DIVU,  32'd100,       32'd7,        10, 32'd2,         32'd14);

    issue(MD_MTLO, 32'd0, 32'd0);
    chk("mtlo_lo", lo, 32'd0);
    chk("mtlo_busy", 32'(busy), 32'd0);
    issue(MD_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    run_op("madd", MD_MADD, 32'd2, 32'd3, 5, 32'h1234_5678, 32'd6);

    // mtlo arriving in the second RUN cycle must be dropped and flagged
    e.name = "mult_drop";
    e.lat  = 5;
    e.hi   = 32'd0;
    e.lo   = 32'h0000_0200;
    q.push_back(e);
    issue(MD_MULT, 32'h10, 32'h20);
    @(posedge clk);
    #1;
    issue(MD_MTLO, 32'h0000_AAAA, 32'd0);
    chk("drop_op_err", 32'(op_err), 32'd1);
    chk("drop_lo_held", lo, 32'd6);
    @(posedge clk);
    #1;
    chk("drop_op_err_clr", 32'(op_err), 32'd0);
    wait_idle(40);

    issue(MD_RSVD, 32'h5555_5555, 32'd0);
    chk("rsvd_op_err", 32'(op_err), 32'd1);
    chk("rsvd_busy", 32'(busy), 32'd0);
    chk("rsvd_hi", hi, 32'd0);
    chk("rsvd_lo", lo, 32'h0000_0200);

    issue(MD_DIV, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    @(negedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("op_err_count", 32'(err_seen), 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
